// File: rtl/io_port_pkg.sv
// io_port_pkg
// Shared types and width helpers for the processor I/O port unit.
//   press_state_t : per-channel debounce FSM states
//   read_state_t  : shared core read handshake states
//   sel_w()       : width of a channel select bus (never less than 1)
//   ptr_w()       : width of a FIFO pointer (never less than 1)
package io_port_pkg;

    typedef enum logic [1:0] {IDLE, ARMING, HELD} press_state_t;
    typedef enum logic       {R_IDLE, R_ACK}      read_state_t;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/io_in_channel.sv
// io_in_channel
// One debounced input channel: 2-flop synchroniser on the pushbutton,
// press FSM that pushes exactly one switch sample per confirmed press,
// a DEPTH-entry FIFO and a sticky overflow flag.
// Ports:
//   clock, reset   : clock, asynchronous active-low reset
//   i_confirm      : raw asynchronous pushbutton
//   i_data         : switch sample (must be stable from press to push)
//   i_pop          : pop the head entry (ignored when empty)
//   i_ovf_clr      : clear the overflow flag
//   o_head         : FIFO head entry
//   o_empty        : FIFO empty
//   o_overflow     : sticky, a press was dropped on a full FIFO
module io_in_channel
    import io_port_pkg::*;
#(
    parameter int IN_W     = 16,
    parameter int DEPTH    = 4,
    parameter int DEBOUNCE = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            i_confirm,
    input  logic [IN_W-1:0] i_data,
    input  logic            i_pop,
    input  logic            i_ovf_clr,
    output logic [IN_W-1:0] o_head,
    output logic            o_empty,
    output logic            o_overflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int NW = PW + 1;
    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [1:0]      r_sync;
    logic            w_sync;
    press_state_t    r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            w_push;
    logic [IN_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [NW-1:0]   r_count;
    logic            w_full, w_pop_ok, w_push_ok;
    logic            r_overflow;

    assign w_sync = r_sync[1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync  <= '0;
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_sync  <= {r_sync[0], i_confirm};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The counter holds the number of consecutive high samples seen so far;
    // the push fires on the edge where that number would reach DEBOUNCE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_push      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_sync) begin
                    if (DEBOUNCE == 1) begin
                        w_push      = 1'b1;
                        w_state_nxt = HELD;
                    end else begin
                        w_state_nxt = ARMING;
                        w_cnt_nxt   = CW'(1);
                    end
                end
            end
            ARMING: begin
                if (!w_sync) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == CW'(DEBOUNCE - 1)) begin
                    w_push      = 1'b1;
                    w_state_nxt = HELD;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            HELD: begin
                if (!w_sync) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_full    = (r_count == NW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_pop_ok  = i_pop && !o_empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_push_ok = w_push && (!w_full || w_pop_ok);
    assign o_head    = r_mem[r_rd_ptr];
    assign o_overflow = r_overflow;

    always_ff @(posedge clock) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + NW'(1);
                2'b01:   r_count <= r_count - NW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push && !w_push_ok) r_overflow <= 1'b1;
            else if (i_ovf_clr)       r_overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/io_port_unit.sv
// io_port_unit
// Processor I/O port unit: N_IN debounced, FIFO-buffered input channels
// read by the core through a req/ack handshake, and N_OUT registered
// output channels with one-cycle update strobes.
// Ports:
//   clock, reset          : clock, asynchronous active-low reset
//   dispositivoDeEntrada  : switch data, channel k at [k*IN_W +: IN_W]
//   confirmaEntrada       : raw pushbuttons, one per input channel
//   cpu_in_req/sel        : core read request and channel select
//   cpu_in_ack/data       : one-cycle ack with extended sample
//   cpu_out_we/sel/data   : core write to an output channel
//   dispositivoDeSaida    : output registers, channel j at [j*DATA_W +: DATA_W]
//   sinalDisplay          : one-cycle update strobe per output channel
//   in_empty, in_overflow : per-input FIFO empty / sticky dropped-press flag
//   ovf_clr               : clears matching in_overflow bits
module io_port_unit
    import io_port_pkg::*;
#(
    parameter int N_IN     = 2,
    parameter int N_OUT    = 2,
    parameter int IN_W     = 16,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int DEBOUNCE = 4,
    parameter int SIGN_EXT = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_IN*IN_W-1:0]    dispositivoDeEntrada,
    input  logic [N_IN-1:0]         confirmaEntrada,
    input  logic                    cpu_in_req,
    input  logic [sel_w(N_IN)-1:0]  cpu_in_sel,
    output logic                    cpu_in_ack,
    output logic [DATA_W-1:0]       cpu_in_data,
    input  logic                    cpu_out_we,
    input  logic [sel_w(N_OUT)-1:0] cpu_out_sel,
    input  logic [DATA_W-1:0]       cpu_out_data,
    output logic [N_OUT*DATA_W-1:0] dispositivoDeSaida,
    output logic [N_OUT-1:0]        sinalDisplay,
    output logic [N_IN-1:0]         in_empty,
    output logic [N_IN-1:0]         in_overflow,
    input  logic [N_IN-1:0]         ovf_clr
);

    localparam int SW_IN  = sel_w(N_IN);
    localparam int SW_OUT = sel_w(N_OUT);

    logic [IN_W-1:0]         w_head [N_IN];
    logic [N_IN-1:0]         w_pop;
    read_state_t             r_rd_state, w_rd_nxt;
    logic                    w_load;
    logic [DATA_W-1:0]       w_load_data;
    logic [DATA_W-1:0]       r_in_data;
    logic [N_OUT*DATA_W-1:0] r_out_regs;
    logic [N_OUT-1:0]        r_strobe;

    function automatic logic [DATA_W-1:0] extend(input logic [IN_W-1:0] x);
        logic [DATA_W-1:0] y;
        y = DATA_W'(x);
        if (SIGN_EXT != 0 && x[IN_W-1]) begin
            for (int i = IN_W; i < DATA_W; i++) y[i] = 1'b1;
        end
        return y;
    endfunction

    for (genvar k = 0; k < N_IN; k++) begin : g_in
        io_in_channel #(
            .IN_W     (IN_W),
            .DEPTH    (DEPTH),
            .DEBOUNCE (DEBOUNCE)
        ) u_ch (
            .clock      (clock),
            .reset      (reset),
            .i_confirm  (confirmaEntrada[k]),
            .i_data     (dispositivoDeEntrada[k*IN_W +: IN_W]),
            .i_pop      (w_pop[k]),
            .i_ovf_clr  (ovf_clr[k]),
            .o_head     (w_head[k]),
            .o_empty    (in_empty[k]),
            .o_overflow (in_overflow[k])
        );
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_state <= R_IDLE;
            r_in_data  <= '0;
        end else begin
            r_rd_state <= w_rd_nxt;
            if (w_load) r_in_data <= w_load_data;
        end
    end

    // An out-of-range select is acknowledged with zero so the core never
    // stalls forever on a bad channel number.
    always_comb begin
        w_rd_nxt    = r_rd_state;
        w_pop       = '0;
        w_load      = 1'b0;
        w_load_data = '0;
        case (r_rd_state)
            R_IDLE: begin
                if (cpu_in_req) begin
                    if (int'(cpu_in_sel) >= N_IN) begin
                        w_load   = 1'b1;
                        w_rd_nxt = R_ACK;
                    end else begin
                        for (int k = 0; k < N_IN; k++) begin
                            if (cpu_in_sel == SW_IN'(k) && !in_empty[k]) begin
                                w_pop[k]    = 1'b1;
                                w_load      = 1'b1;
                                w_load_data = extend(w_head[k]);
                                w_rd_nxt    = R_ACK;
                            end
                        end
                    end
                end
            end
            R_ACK:   w_rd_nxt = R_IDLE;
            default: w_rd_nxt = R_IDLE;
        endcase
    end

    assign cpu_in_ack  = (r_rd_state == R_ACK);
    assign cpu_in_data = r_in_data;

    // Writes to a select with no matching channel fall through the loop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out_regs <= '0;
            r_strobe   <= '0;
        end else begin
            r_strobe <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                if (cpu_out_we && cpu_out_sel == SW_OUT'(j)) begin
                    r_out_regs[j*DATA_W +: DATA_W] <= cpu_out_data;
                    r_strobe[j]                    <= 1'b1;
                end
            end
        end
    end

    assign dispositivoDeSaida = r_out_regs;
    assign sinalDisplay       = r_strobe;

endmodule

// File: tb/tb_io_port_unit.sv
module tb_io_port_unit;

    localparam int N_IN     = 2;
    localparam int N_OUT    = 3;
    localparam int IN_W     = 16;
    localparam int DATA_W   = 32;
    localparam int DEPTH    = 4;
    localparam int DEBOUNCE = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic [N_IN*IN_W-1:0]    din      = '0;
    logic [N_IN-1:0]         conf     = '0;
    logic [N_IN-1:0]         ovf_clr  = '0;
    logic                    req      = 1'b0;
    logic [0:0]              in_sel   = '0;
    logic                    we       = 1'b0;
    logic [1:0]              out_sel  = '0;
    logic [DATA_W-1:0]       out_data = '0;

    logic                    ack_z, ack_s;
    logic [DATA_W-1:0]       data_z, data_s;
    logic [N_OUT*DATA_W-1:0] dout_z, dout_s;
    logic [N_OUT-1:0]        disp_z, disp_s;
    logic [N_IN-1:0]         empty_z, empty_s, ovf_z, ovf_s;

    io_port_unit #(
        .N_IN(N_IN), .N_OUT(N_OUT), .IN_W(IN_W), .DATA_W(DATA_W),
        .DEPTH(DEPTH), .DEBOUNCE(DEBOUNCE), .SIGN_EXT(0)
    ) u_dut_z (
        .clock(clock), .reset(reset),
        .dispositivoDeEntrada(din), .confirmaEntrada(conf),
        .cpu_in_req(req), .cpu_in_sel(in_sel),
        .cpu_in_ack(ack_z), .cpu_in_data(data_z),
        .cpu_out_we(we), .cpu_out_sel(out_sel), .cpu_out_data(out_data),
        .dispositivoDeSaida(dout_z), .sinalDisplay(disp_z),
        .in_empty(empty_z), .in_overflow(ovf_z), .ovf_clr(ovf_clr)
    );

    io_port_unit #(
        .N_IN(N_IN), .N_OUT(N_OUT), .IN_W(IN_W), .DATA_W(DATA_W),
        .DEPTH(DEPTH), .DEBOUNCE(DEBOUNCE), .SIGN_EXT(1)
    ) u_dut_s (
        .clock(clock), .reset(reset),
        .dispositivoDeEntrada(din), .confirmaEntrada(conf),
        .cpu_in_req(req), .cpu_in_sel(in_sel),
        .cpu_in_ack(ack_s), .cpu_in_data(data_s),
        .cpu_out_we(we), .cpu_out_sel(out_sel), .cpu_out_data(out_data),
        .dispositivoDeSaida(dout_s), .sinalDisplay(disp_s),
        .in_empty(empty_s), .in_overflow(ovf_s), .ovf_clr(ovf_clr)
    );

    int n_checks  = 0;
    int n_errors  = 0;
    int ack_cnt   = 0;
    int exp_acks  = 0;
    logic [IN_W-1:0] exp_q [N_IN][$];
    int mdl_cnt [N_IN];

    always @(negedge clock) begin
        if (ack_z) ack_cnt <= ack_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_push(input int ch, input logic [IN_W-1:0] val);
        if (mdl_cnt[ch] < DEPTH) begin
            exp_q[ch].push_back(val);
            mdl_cnt[ch]++;
        end
    endtask

    task automatic press(input int ch, input logic [IN_W-1:0] val, input int hold);
        @(negedge clock);
        din[ch*IN_W +: IN_W] = val;
        conf[ch] = 1'b1;
        model_push(ch, val);
        repeat (hold) @(negedge clock);
        conf[ch] = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic compare_word(input int ch);
        logic [IN_W-1:0] e;
        if (exp_q[ch].size() == 0) begin
            check_val("read_unexpected", 64'(1), 64'(0));
        end else begin
            e = exp_q[ch].pop_front();
            mdl_cnt[ch]--;
            check_val("read_zext", 64'(data_z), 64'({16'h0000, e}));
            check_val("read_sext", 64'(data_s), 64'({{16{e[IN_W-1]}}, e}));
        end
    endtask

    task automatic read_ch(input int ch);
        bit got;
        got = 1'b0;
        @(negedge clock);
        in_sel = ch[0:0];
        req    = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge clock);
            #1;
            if (ack_z) got = 1'b1;
        end
        req = 1'b0;
        if (!got) begin
            check_val("read_timeout", 64'(0), 64'(1));
        end else begin
            exp_acks++;
            compare_word(ch);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int edge_idx;
        for (int k = 0; k < N_IN; k++) mdl_cnt[k] = 0;

        #1;
        check_val("rst_empty", 64'(empty_z), 64'(2'b11));
        check_val("rst_ovf", 64'(ovf_z), 64'(0));
        check_val("rst_ack", 64'(ack_z), 64'(0));
        check_val("rst_data", 64'(data_z), 64'(0));
        check_val("rst_disp", 64'(disp_z), 64'(0));
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Press ch0 with 0x8001, push expected on the 6th edge.
        @(negedge clock);
        din[15:0] = 16'h8001;
        conf[0]   = 1'b1;
        model_push(0, 16'h8001);
        repeat (5) @(posedge clock);
        #1 check_val("empty_before_push", 64'(empty_z[0]), 64'(1));
        @(posedge clock);
        #1 check_val("empty_at_push", 64'(empty_z[0]), 64'(0));
        repeat (5) @(negedge clock);
        conf[0] = 1'b0;
        repeat (4) @(negedge clock);
        read_ch(0);
        check_val("single_push", 64'(empty_z[0]), 64'(1));

        // Glitch shorter than the debounce window.
        @(negedge clock);
        din[15:0] = 16'h5A5A;
        conf[0]   = 1'b1;
        repeat (3) @(negedge clock);
        conf[0] = 1'b0;
        repeat (8) @(negedge clock);
        check_val("glitch_no_push", 64'(empty_z[0]), 64'(1));

        // Five presses into a four-deep FIFO.
        press(1, 16'h1111, 8);
        press(1, 16'h2222, 8);
        press(1, 16'h3333, 8);
        press(1, 16'h4444, 8);
        press(1, 16'h5555, 8);
        #1;
        check_val("ovf_set", 64'(ovf_z[1]), 64'(1));
        check_val("ovf_other_ch", 64'(ovf_z[0]), 64'(0));
        for (int i = 0; i < 4; i++) read_ch(1);
        check_val("drained_empty", 64'(empty_z[1]), 64'(1));
        check_val("ovf_sticky", 64'(ovf_z[1]), 64'(1));
        @(negedge clock);
        ovf_clr[1] = 1'b1;
        @(negedge clock);
        ovf_clr[1] = 1'b0;
        #1 check_val("ovf_cleared", 64'(ovf_z[1]), 64'(0));

        // Core stalls on an empty FIFO until a press arrives.
        @(negedge clock);
        #1 base = ack_cnt;
        in_sel = 1'b0;
        req    = 1'b1;
        repeat (20) @(negedge clock);
        #1 check_val("stall_no_ack", 64'(ack_cnt - base), 64'(0));
        @(negedge clock);
        din[15:0] = 16'h0042;
        conf[0]   = 1'b1;
        model_push(0, 16'h0042);
        edge_idx = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clock);
            #1;
            if (ack_z && edge_idx == 0) begin
                edge_idx = i;
                req = 1'b0;
                exp_acks++;
                compare_word(0);
            end
        end
        req = 1'b0;
        check_val("stall_ack_edge", 64'(edge_idx), 64'(DEBOUNCE + 3));
        conf[0] = 1'b0;
        repeat (8) @(negedge clock);
        #1 check_val("stall_one_ack", 64'(ack_cnt - base), 64'(1));
        check_val("stall_empty", 64'(empty_z[0]), 64'(1));

        // Output channel write and an out-of-range select.
        @(negedge clock);
        we       = 1'b1;
        out_sel  = 2'd1;
        out_data = 32'hDEADBEEF;
        @(posedge clock);
        #1 we = 1'b0;
        check_val("out_ch1", 64'(dout_z[63:32]), 64'(32'hDEADBEEF));
        check_val("out_ch0", 64'(dout_z[31:0]), 64'(0));
        check_val("strobe_ch1", 64'(disp_z), 64'(3'b010));
        @(posedge clock);
        #1 check_val("strobe_one_cycle", 64'(disp_z), 64'(0));
        @(negedge clock);
        we       = 1'b1;
        out_sel  = 2'd3;
        out_data = 32'h12345678;
        @(posedge clock);
        #1 we = 1'b0;
        check_val("bad_sel_strobe", 64'(disp_z), 64'(0));
        check_val("bad_sel_ch0", 64'(dout_z[31:0]), 64'(0));
        check_val("bad_sel_ch1", 64'(dout_z[63:32]), 64'(32'hDEADBEEF));
        check_val("bad_sel_ch2", 64'(dout_z[95:64]), 64'(0));

        // Reset with two words queued and ch0 mid-debounce.
        press(1, 16'hAAAA, 8);
        press(1, 16'hBBBB, 8);
        #1 check_val("queued_nonempty", 64'(empty_z[1]), 64'(0));
        @(negedge clock);
        din[15:0] = 16'h7777;
        conf[0]   = 1'b1;
        repeat (4) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check_val("arst_empty", 64'(empty_z), 64'(2'b11));
        check_val("arst_ovf", 64'(ovf_z), 64'(0));
        check_val("arst_ack", 64'(ack_z), 64'(0));
        check_val("arst_data", 64'(data_z), 64'(0));
        check_val("arst_out_ch1", 64'(dout_z[63:32]), 64'(0));
        check_val("arst_disp", 64'(disp_z), 64'(0));
        for (int k = 0; k < N_IN; k++) begin
            exp_q[k].delete();
            mdl_cnt[k] = 0;
        end
        conf[0] = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (10) @(negedge clock);
        #1 check_val("post_rst_empty", 64'(empty_z), 64'(2'b11));
        check_val("ack_total", 64'(ack_cnt), 64'(exp_acks));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
